// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle MIPS-subset controller.
//   - opcode constants for the five supported instructions
//   - 4-bit controller state encoding
//   - aluOp / aluSrcB / pcSource field encodings
//   - packed bundle of every control output, used between FSM and decoder
package ctrl_pkg;

  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_J      = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       instrDone;
    logic       illegalOp;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_R_TYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)    || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory signal bundle.
//   master : controller side (drives all control strobes and state)
//   slave  : datapath side (drives op from IR and memory memReady)
interface multicycle_ctrl_if;

  logic [5:0] op;
  logic       memReady;
  logic       pcWrite;
  logic       pcWriteCond;
  logic       iorD;
  logic       memRead;
  logic       memWrite;
  logic       irWrite;
  logic       memtoReg;
  logic       regDst;
  logic       regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic [1:0] pcSource;
  logic       instrDone;
  logic       illegalOp;
  logic [3:0] state;

  modport master (
    input  op, memReady,
    output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
           memtoReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
           pcSource, instrDone, illegalOp, state
  );

  modport slave (
    output op, memReady,
    input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
           memtoReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
           pcSource, instrDone, illegalOp, state
  );

endinterface

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: combinational state -> control decoder.
//   state_i    : current controller state
//   memReady_i : memory handshake (gates FETCH writes and SW completion)
//   op_i       : IR opcode, only used to flag illegal opcodes in DECODE
//   ctrl_o     : full control bundle; every field defaults to 0
import ctrl_pkg::*;

module mc_ctrl_outdec (
  input  state_t     state_i,
  input  logic       memReady_i,
  input  logic [5:0] op_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.memRead  = 1'b1;
        ctrl_o.aluSrcB  = SRCB_FOUR;
        ctrl_o.aluOp    = ALUOP_ADD;
        ctrl_o.pcSource = PCSRC_ALU;
        // IR and PC load only in the cycle the fetch actually completes
        ctrl_o.irWrite  = memReady_i;
        ctrl_o.pcWrite  = memReady_i;
      end
      S_DECODE: begin
        ctrl_o.aluSrcB   = SRCB_IMM_SH2;
        ctrl_o.aluOp     = ALUOP_ADD;
        ctrl_o.illegalOp = ~is_legal_op(op_i);
      end
      S_MEMADR: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_IMM;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.memRead = 1'b1;
        ctrl_o.iorD    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.memtoReg  = 1'b1;
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.memWrite  = 1'b1;
        ctrl_o.iorD      = 1'b1;
        ctrl_o.instrDone = memReady_i;
      end
      S_EXEC: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_REG;
        ctrl_o.aluOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl_o.regDst    = 1'b1;
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.instrDone = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.aluSrcA     = 1'b1;
        ctrl_o.aluSrcB     = SRCB_REG;
        ctrl_o.aluOp       = ALUOP_SUB;
        ctrl_o.pcWriteCond = 1'b1;
        ctrl_o.pcSource    = PCSRC_ALUOUT;
        ctrl_o.instrDone   = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pcWrite   = 1'b1;
        ctrl_o.pcSource  = PCSRC_JUMP;
        ctrl_o.instrDone = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style main controller for the multicycle
// MIPS-subset datapath (R-type, LW, SW, BEQ, J).
//   clk : system clock
//   rst : synchronous active-high reset, returns to FETCH
//   bus : multicycle_ctrl_if.master (op/memReady in, controls/state out)
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 when memory ready
// DECODE | read registers, branch target into ALUOut, dispatch on op
// MEMADR | compute load/store address
// MEMRD  | load data read, wait for memory
// MEMWB  | write loaded data to rt
// MEMWR  | store data write, wait for memory
// EXEC   | R-type ALU operation
// RWB    | write ALU result to rd
// BRANCH | compare and conditionally load branch target
// JUMP   | load jump target
import ctrl_pkg::*;

module multicycle_ctrl (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.memReady) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R_TYPE:    state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // Only LW and SW reach MEMADR, so anything but SW is treated as a load
      S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.memReady) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (bus.memReady) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      // unused codes 10..15 recover to FETCH
      default:  state_d = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state_i    (state_q),
    .memReady_i (bus.memReady),
    .op_i       (bus.op),
    .ctrl_o     (ctrl)
  );

  assign bus.pcWrite     = ctrl.pcWrite;
  assign bus.pcWriteCond = ctrl.pcWriteCond;
  assign bus.iorD        = ctrl.iorD;
  assign bus.memRead     = ctrl.memRead;
  assign bus.memWrite    = ctrl.memWrite;
  assign bus.irWrite     = ctrl.irWrite;
  assign bus.memtoReg    = ctrl.memtoReg;
  assign bus.regDst      = ctrl.regDst;
  assign bus.regWrite    = ctrl.regWrite;
  assign bus.aluSrcA     = ctrl.aluSrcA;
  assign bus.aluSrcB     = ctrl.aluSrcB;
  assign bus.aluOp       = ctrl.aluOp;
  assign bus.pcSource    = ctrl.pcSource;
  assign bus.instrDone   = ctrl.instrDone;
  assign bus.illegalOp   = ctrl.illegalOp;
  assign bus.state       = state_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle main controller for the MIPS-subset datapath: R-type, LW, SW, BEQ, J. A Moore-style state machine sequences the shared ALU, the unified instruction/data memory, the IR, the PC and the register file over several cycles per instruction. It replaces the single-cycle opcode decoder when the datapath runs in multicycle form, and it waits on a memory ready handshake.

## Interface
Parameters:
- none; opcode values, state encodings and aluOp encodings live in the shared package.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset; one clock, sampled on the rising edge of clk
- op  in  6  IR[31:26]; valid from DECODE onward
- memReady  in  1  memory completes the current read/write this cycle
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load if ALU zero (datapath ANDs with zero)
- iorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- memRead  out  1  memory read request, held until memReady
- memWrite  out  1  memory write request, held until memReady
- irWrite  out  1  IR load
- memtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
- regDst  out  1  destination register: 0 = rt, 1 = rd
- regWrite  out  1  register file write enable
- aluSrcA  out  1  0 = PC, 1 = register A
- aluSrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- aluOp  out  2  00 = add, 01 = sub, 10 = use funct
- pcSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- instrDone  out  1  high on the last cycle of each retired instruction
- illegalOp  out  1  high in DECODE when op is not one of the five supported opcodes
- state  out  4  current state, for debug and the testbench

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9. Codes 10–15 are unreachable; if entered, the next state is FETCH.
- Any output not listed for a state is 0. No X outputs in any state.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00.
  - irWrite and pcWrite equal memReady (Mealy gating).
  - Stay in FETCH until memReady=1, then go to DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00; the branch target goes into ALUOut. Next state by op:
  - LW or SW → MEMADR
  - R_TYPE → EXEC
  - BEQ → BRANCH
  - J → JUMP
  - any other op → FETCH, with illegalOp=1
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Next: LW → MEMRD, SW → MEMWR.
- MEMRD: memRead=1, iorD=1. Stay until memReady=1, then go to MEMWB.
- MEMWB: regDst=0, memtoReg=1, regWrite=1, instrDone=1. Next: FETCH.
- MEMWR: memWrite=1, iorD=1. Stay until memReady=1. When memReady=1, instrDone=1 and next state is FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10. Next: RWB.
- RWB: regDst=1, memtoReg=0, regWrite=1, instrDone=1. Next: FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01, instrDone=1. Next: FETCH.
- JUMP: pcWrite=1, pcSource=10, instrDone=1. Next: FETCH.

## Timing
- Reset:
  - rst is synchronous: with rst=1 at a rising edge, state=FETCH after that edge, regardless of the current state. This includes reset mid-instruction and reset while a memory request is pending.
  - After reset, outputs are the FETCH values; no write strobe (regWrite, memWrite) is asserted.
- Cycle counts with memReady always 1:
  - R-type 4, LW 5, SW 4, BEQ 3, J 3, illegal opcode 2.
  - Each cycle memReady is low in FETCH, MEMRD or MEMWR adds one cycle.
- memRead/memWrite stay asserted and stable while waiting; they deassert in the cycle after memReady=1.
- memReady is ignored in every state except FETCH, MEMRD and MEMWR.
- op is ignored in every state except DECODE and MEMADR.
- instrDone and illegalOp are never high in the same cycle.

## Structure
- Package ctrl_pkg holds:
  - opcode constants: R_TYPE=000000, LW=100011, SW=101011, BEQ=000100, J=000010
  - the 4-bit state enum
  - aluOp, aluSrcB and pcSource encodings
- Natural split into two parts:
  - the next-state register and transition logic in multicycle_ctrl
  - a combinational state→control decoder as sub-module mc_ctrl_outdec (inputs: state, memReady; outputs: all control signals)

## Test plan
- Reset: rst=1 held 2 cycles from mid-LW (state=MEMRD) → state=0 on the next edge; memRead=1 and iorD=0 (FETCH values); regWrite=0 and memWrite=0.
- R-type, memReady=1: state sequence 0,1,6,7,0; regWrite=1 and regDst=1 only in cycle 4; instrDone pulses once.
- LW with memReady low 2 cycles in FETCH and 3 cycles in MEMRD: 10 cycles total; memRead is held steady while waiting; irWrite=1 only in the ready cycle.
- SW then BEQ: MEMWR has memWrite=1, iorD=1 and instrDone only when memReady=1. BRANCH has aluOp=01, pcWriteCond=1, pcSource=01. SW takes 4 cycles and BEQ 3.
- J: state sequence 0,1,9,0; pcWrite=1 and pcSource=10 in the JUMP state.
- Illegal op=111111: DECODE asserts illegalOp=1 and the next state is FETCH. Forcing state to 12 → next state is FETCH.
